pattern_writer: RTL and testbench
=================================

PATTERN_WRITER -- requirements
Module: pattern_writer

Interface
REQ-001 SHALL have parameter HDISP, default 800, meaning pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, meaning lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, meaning framebuffer byte base address in SDRAM.
REQ-004 SHALL have port sys_clk  input  1  system clock 100 MHz.
REQ-005 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to paint one frame.
REQ-007 SHALL have port pattern_sel  input  2  pattern choice, sampled on accepted start.
REQ-008 SHALL have port busy  output  1  frame write in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-010 SHALL have port avalon_ifh  avalon_if host modport  32-bit data  Avalon-MM write host toward the SDRAM interconnect; it is the writer for the framebuffer that the vga block reads.

Function
REQ-011 SHALL implement FSM IDLE -> WRITE -> DONE -> IDLE.
REQ-012 IDLE: start=1 SHALL latch pattern_sel, clear x,y to 0, and enter WRITE next cycle; start is ignored in WRITE and DONE.
REQ-013 WRITE SHALL assert write=1 and byteenable=4'hF, and keep address and writedata stable while waitrequest=1.
REQ-014 SHALL accept a transfer only on cycles where write=1 and waitrequest=0, advancing x; at x=HDISP-1 x wraps to 0 and y increments.
REQ-015 address SHALL be BASE_ADDR + 4*(y*HDISP + x), computed 32-bit with wrap-around.
REQ-016 writedata SHALL be {8'h00,R,G,B}.
REQ-017 pattern 0: colour bars, bar index = (x*8)/HDISP, RGB bits = bar index bits {2,1,0}, each 8'hFF or 8'h00.
REQ-018 pattern 1: 16x16 checkerboard, white when x[4]^y[4]=1, else black.
REQ-019 pattern 2: R=x[7:0], G=y[7:0], B=8'h00; pattern 3: 32'h00FFFFFF.
REQ-020 Acceptance of pixel (HDISP-1,VDISP-1) SHALL move to DONE, deassert write the next cycle, and assert done=1 for exactly one cycle.
REQ-021 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-022 read SHALL be tied 0; readdata and readdatavalid SHALL be ignored.
REQ-023 Exactly HDISP*VDISP transfers SHALL be issued per frame, none duplicated or skipped regardless of waitrequest pattern.

Reset
REQ-024 sys_rst=1 SHALL force IDLE, x=y=0, write=0, address=0, writedata=0, byteenable=0, busy=0, done=0, at any time including mid-frame; the partial frame is abandoned.
REQ-025 After reset release the first action SHALL be waiting for start.

Configuration
REQ-026 With PATTERN_WRITER_ANIM_EN defined, an internal 8-bit frame counter SHALL increment on each done pulse (wrap 255->0), and the pattern x coordinate SHALL be (x + frame_cnt) mod HDISP, so bars scroll; the counter is cleared by reset.
REQ-027 Without PATTERN_WRITER_ANIM_EN, the offset SHALL be 0 and no frame counter logic SHALL exist; ports are identical in both builds.

Structure
REQ-028 A package pattern_writer_pkg SHALL hold the FSM state enum, the pattern_sel encoding constants and the 32-bit pixel type.
REQ-029 A sub-module pixel_scan_counter SHALL hold the x/y counters with advance-on-accept and last-pixel flag.

Verification (HDISP=16, VDISP=4, BASE_ADDR=32'h100)
REQ-030 waitrequest=0, start with sel=0 -> 64 writes at addresses 0x100..0x1FC step 4; x=0 data 0x00000000, x=2 data 0x000000FF, x=15 data 0x00FFFFFF; done one cycle after the last write.
REQ-031 waitrequest=1 for 5 cycles on every transfer -> address and data unchanged while stalled; still exactly 64 writes.
REQ-032 Second start pulse mid-frame -> ignored; 64 writes total, one done pulse.
REQ-033 sys_rst asserted after 20 writes -> write=0 and busy=0 immediately; new start begins again at address 0x100.
REQ-034 sel=2 -> pixel (x=5,y=3) at address 0x100+4*53=0x1D4 with data 0x00050300.
REQ-035 With PATTERN_WRITER_ANIM_EN, two frames with sel=0 -> second frame pixel x=0 data equals first frame pixel x=1 data.

Source files
------------

// File: rtl/pattern_writer_pkg.sv
// rtl/pattern_writer_pkg.sv - shared types, pattern encodings and pixel colour helper for pattern_writer
package pattern_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_CHECKER = 2'd1;
    localparam logic [1:0] PAT_GRAD    = 2'd2;
    localparam logic [1:0] PAT_WHITE   = 2'd3;

    typedef logic [31:0] pixel_t;

    // px is the (possibly scrolled) x coordinate, always below hdisp.
    function automatic pixel_t make_pixel(input logic [1:0]  sel,
                                          input logic [31:0] px,
                                          input logic [7:0]  py,
                                          input logic [31:0] hdisp);
        logic [2:0] bar;
        pixel_t     p;
        bar = 3'((px << 3) / hdisp);
        case (sel)
            PAT_BARS:    p = {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            PAT_CHECKER: p = (px[4] ^ py[4]) ? 32'h00FF_FFFF : 32'h0000_0000;
            PAT_GRAD:    p = {8'h00, px[7:0], py, 8'h00};
            default:     p = 32'h00FF_FFFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/avalon_if.sv
// rtl/avalon_if.sv - 32-bit Avalon-MM bundle with host and agent views
interface avalon_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport host (
        output address, write, writedata, byteenable, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport agent (
        input  address, write, writedata, byteenable, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/pixel_scan_counter.sv
// rtl/pixel_scan_counter.sv - raster x/y counters that advance on each accepted transfer
module pixel_scan_counter #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_end, y_end;

    assign x_end  = (x_q == XW'(HDISP - 1));
    assign y_end  = (y_q == YW'(VDISP - 1));
    assign last_o = x_end && y_end;
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/pattern_writer.sv
// rtl/pattern_writer.sv - paints one test-pattern frame into SDRAM over Avalon-MM; PATTERN_WRITER_ANIM_EN scrolls the pattern per frame
module pattern_writer
    import pattern_writer_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [1:0] pattern_sel,
    output logic       busy,
    output logic       done,
    avalon_if.host     avalon_ifh
);
    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last_pix;
    logic          clear;
    logic          accept;
    logic          in_write;
    logic [31:0]   px32, py32, lin;
    pixel_t        pix;
    logic          unused_sink;

    assign in_write = (state_q == ST_WRITE);
    assign accept   = in_write && !avalon_ifh.waitrequest;

    pixel_scan_counter #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_scan (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clear_i   (clear),
        .advance_i (accept),
        .x_o       (x),
        .y_o       (y),
        .last_o    (last_pix)
    );

`ifdef PATTERN_WRITER_ANIM_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt_q <= 8'd0;
        end else if (state_q == ST_DONE) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign px32 = (32'(x) + 32'(frame_cnt_q)) % 32'(HDISP);
`else
    assign px32 = 32'(x);
`endif

    assign py32 = 32'(y);
    // Address uses the unscrolled coordinate; only the colour follows px32.
    assign lin  = py32 * 32'(HDISP) + 32'(x);
    assign pix  = make_pixel(sel_q, px32, py32[7:0], 32'(HDISP));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = pattern_sel;
                    clear   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept && last_pix) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= PAT_BARS;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign avalon_ifh.write      = in_write;
    assign avalon_ifh.byteenable = in_write ? 4'hF : 4'h0;
    assign avalon_ifh.address    = in_write ? BASE_ADDR + (lin << 2) : 32'h0;
    assign avalon_ifh.writedata  = in_write ? pix : 32'h0;
    assign avalon_ifh.read       = 1'b0;
    assign busy                  = (state_q != ST_IDLE);
    assign done                  = (state_q == ST_DONE);

    assign unused_sink = ^{avalon_ifh.readdata, avalon_ifh.readdatavalid, py32[31:8]};
endmodule

// File: tb/tb_pattern_writer.sv
// tb/tb_pattern_writer.sv - scoreboard bench for pattern_writer at HDISP=16, VDISP=4, BASE_ADDR=0x100
module tb_pattern_writer;
    localparam int HD = 16;
    localparam int VD = 4;
`ifdef PATTERN_WRITER_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [31:0] data;
    } spot_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       busy, done;

    avalon_if av ();

    pattern_writer #(.HDISP(HD), .VDISP(VD), .BASE_ADDR(32'h100)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .pattern_sel (pattern_sel),
        .busy        (busy),
        .done        (done),
        .avalon_ifh  (av)
    );

    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   acc_count = 0, done_count = 0;
    int   cycle = 0, last_acc = 0;
    int   wr_mode = 0;
    int   cur_sel = 0, cur_fc = 0;
    int   fc_model = 0;
    spot_t spots[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int sel, input int x, input int y, input int fc);
        int px, bar;
        px  = (x + fc) % HD;
        bar = (px * 8) / HD;
        case (sel)
            0: return {8'h00, ((bar & 4) != 0) ? 8'hFF : 8'h00,
                              ((bar & 2) != 0) ? 8'hFF : 8'h00,
                              ((bar & 1) != 0) ? 8'hFF : 8'h00};
            1: return ((((px >> 4) ^ (y >> 4)) & 1) != 0) ? 32'h00FFFFFF : 32'h0;
            2: return {8'h00, 8'(px), 8'(y), 8'h00};
            default: return 32'h00FFFFFF;
        endcase
    endfunction

    always @(posedge sys_clk) cycle++;

    // waitrequest driver: mode 1 stalls five cycles before each accepted transfer
    initial begin
        int stall;
        stall = 0;
        av.waitrequest   = 1'b0;
        av.readdata      = 32'hDEAD_BEEF;
        av.readdatavalid = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (wr_mode == 1 && av.write) begin
                if (stall < 5) begin
                    av.waitrequest = 1'b1;
                    stall++;
                end else begin
                    av.waitrequest = 1'b0;
                    stall = 0;
                end
            end else begin
                av.waitrequest = 1'b0;
                stall = 0;
            end
        end
    end

    // monitor: compares every presented write against the head of the scoreboard
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst) begin
            if (av.write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=none", av.address);
                end else begin
                    e = exp_q[0];
                    chk("address", av.address, e.addr);
                    chk("writedata", av.writedata, e.data);
                    chk("byteenable", 32'(av.byteenable), 32'hF);
                    chk("read_tied", 32'(av.read), 32'h0);
                    if (!av.waitrequest) begin
                        void'(exp_q.pop_front());
                        acc_count++;
                        last_acc = cycle;
                        if (cur_fc == 0) begin
                            foreach (spots[i]) begin
                                if (spots[i].sel == cur_sel && spots[i].addr == av.address)
                                    chk("spot_pixel", av.writedata, spots[i].data);
                            end
                        end
                    end
                end
            end
            if (done) begin
                done_count++;
                chk("done_latency", 32'(cycle - last_acc), 32'd1);
                chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
                fc_model = (fc_model + 1) % 256;
            end
        end
    end

    task automatic run_frame(input int sel, input int mode, input bit extra_start);
        int n;
        cur_sel = sel;
        cur_fc  = ANIM ? fc_model : 0;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                exp_q.push_back('{32'h100 + 32'(4 * (y * HD + x)), exp_pix(sel, x, y, cur_fc)});
        acc_count  = 0;
        done_count = 0;
        wr_mode    = mode;
        @(posedge sys_clk); #1;
        start = 1'b1;
        pattern_sel = 2'(sel);
        @(posedge sys_clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (extra_start) begin
            repeat (10) @(posedge sys_clk);
            #1;
            start = 1'b1;
            pattern_sel = 2'd3;
            @(posedge sys_clk); #1;
            start = 1'b0;
            chk("busy_mid_frame", 32'(busy), 32'd1);
        end
        n = 0;
        while (done_count == 0 && n < 3000) begin
            @(posedge sys_clk); #2;
            n++;
        end
        if (done_count == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required=64 writes", acc_count);
        end
        repeat (3) @(posedge sys_clk);
        #2;
        chk("write_count", 32'(acc_count), 32'd64);
        chk("done_pulses", 32'(done_count), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("write_after_done", 32'(av.write), 32'd0);
        wr_mode = 0;
    endtask

    initial begin
        int n;
        spots[0] = '{0, 32'h100, 32'h0000_0000};
        spots[1] = '{0, 32'h108, 32'h0000_00FF};
        spots[2] = '{0, 32'h13C, 32'h00FF_FFFF};
        spots[3] = '{2, 32'h1D4, 32'h0005_0300};
        spots[4] = '{1, 32'h104, 32'h0000_0000};
        spots[5] = '{3, 32'h1FC, 32'h00FF_FFFF};

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_write", 32'(av.write), 32'd0);
        chk("rst_address", av.address, 32'h0);
        chk("rst_writedata", av.writedata, 32'h0);
        chk("rst_byteenable", 32'(av.byteenable), 32'h0);
        chk("rst_read", 32'(av.read), 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("idle_write", 32'(av.write), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        run_frame(0, 0, 1'b0);
        run_frame(0, 1, 1'b0);
        run_frame(1, 0, 1'b1);
        run_frame(2, 0, 1'b0);
        run_frame(3, 1, 1'b0);

        // abandon a frame after exactly 20 accepted writes
        cur_sel = 0;
        cur_fc  = ANIM ? fc_model : 0;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                exp_q.push_back('{32'h100 + 32'(4 * (y * HD + x)), exp_pix(0, x, y, cur_fc)});
        acc_count = 0;
        @(posedge sys_clk); #1;
        start = 1'b1;
        pattern_sel = 2'd0;
        @(posedge sys_clk); #1;
        start = 1'b0;
        n = 0;
        while (acc_count < 20 && n < 500) begin
            @(negedge sys_clk); #1;
            n++;
        end
        if (acc_count < 20) begin
            checks++;
            errors++;
            $display("FAIL partial_frame_timeout actual=%0d required=20", acc_count);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        #1;
        chk("midrst_write", 32'(av.write), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_address", av.address, 32'h0);
        chk("midrst_writedata", av.writedata, 32'h0);
        chk("midrst_byteenable", 32'(av.byteenable), 32'h0);
        exp_q.delete();
        fc_model = 0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("postrst_write", 32'(av.write), 32'd0);

        run_frame(2, 0, 1'b0);
        run_frame(0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
